// File: rtl/joypad_responder.sv
// Two-wire bus target that returns a 32-bit button snapshot one byte at a time, LSB byte first.
// Latency: sda_out follows a scl_in falling edge by 3 clk cycles; START/STOP release sda_out 2 cycles after the sda_in edge.
// Backpressure: none; the initiator paces every bit with scl, and the 32-bit snapshot wraps on continued ACKs.
module joypad_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h52
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_out,
    input  logic [31:0] buttons,
    output logic        busy,
    output logic        xfer_done
);

    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, TX, RX_ACK, WAIT_STOP} state_t;

    logic        scl_s1_q, scl_s2_q, scl_prev_q;
    logic        sda_s1_q, sda_s2_q, sda_prev_q;
    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [31:0] snap_q, snap_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic        drive_low_q, drive_low_d;
    logic        xfer_done_q, xfer_done_d;

    logic scl_rise, scl_fall, start_det, stop_det, tx_bit;

    // Bus conditions are judged only from the synchronized lines and their previous values.
    assign scl_rise  = scl_s2_q & ~scl_prev_q;
    assign scl_fall  = ~scl_s2_q & scl_prev_q;
    assign start_det = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
    assign stop_det  = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;

    // Bit counter counts bits already driven, so ~bit_cnt[2:0] selects MSB-first within the byte.
    assign tx_bit = snap_q[{byte_idx_q, ~bit_cnt_q[2:0]}];

    // START/STOP release the line combinationally in the cycle they are detected.
    assign sda_out   = ~(drive_low_q & ~start_det & ~stop_det);
    assign busy      = (state_q != IDLE);
    assign xfer_done = xfer_done_q;

    // Two-flop synchronizers plus the previous-value flops used for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_s1_q   <= scl_in;
            scl_s2_q   <= scl_s1_q;
            scl_prev_q <= scl_s2_q;
            sda_s1_q   <= sda_in;
            sda_s2_q   <= sda_s1_q;
            sda_prev_q <= sda_s2_q;
        end
    end

    // Protocol state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 4'd0;
            shreg_q     <= 8'd0;
            snap_q      <= 32'd0;
            byte_idx_q  <= 2'd0;
            drive_low_q <= 1'b0;
            xfer_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            snap_q      <= snap_d;
            byte_idx_q  <= byte_idx_d;
            drive_low_q <= drive_low_d;
            xfer_done_q <= xfer_done_d;
        end
    end

    // Next-state logic; START and STOP override whatever the current state decided.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        snap_d      = snap_q;
        byte_idx_d  = byte_idx_q;
        drive_low_d = drive_low_q;
        xfer_done_d = 1'b0;

        case (state_q)
            ADDR: begin
                if (scl_rise && bit_cnt_q < 4'd8) begin
                    shreg_d   = {shreg_q[6:0], sda_s2_q};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else if (scl_fall && bit_cnt_q == 4'd8) begin
                    bit_cnt_d = 4'd0;
                    if (shreg_q[7:1] == DEV_ADDR && shreg_q[0]) begin
                        state_d     = ADDR_ACK;
                        drive_low_d = 1'b1;
                        snap_d      = buttons;
                        byte_idx_d  = 2'd0;
                    end else begin
                        state_d     = WAIT_STOP;
                        drive_low_d = 1'b0;
                    end
                end
            end
            ADDR_ACK: begin
                // The falling edge that ends the ACK also presents the first data bit.
                if (scl_fall) begin
                    state_d     = TX;
                    drive_low_d = ~tx_bit;
                    bit_cnt_d   = 4'd1;
                end
            end
            TX: begin
                if (scl_fall) begin
                    if (bit_cnt_q < 4'd8) begin
                        drive_low_d = ~tx_bit;
                        bit_cnt_d   = bit_cnt_q + 4'd1;
                    end else begin
                        drive_low_d = 1'b0;
                        state_d     = RX_ACK;
                    end
                end
            end
            RX_ACK: begin
                if (scl_rise) begin
                    if (!sda_s2_q) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        bit_cnt_d  = 4'd0;
                        state_d    = TX;
                    end else begin
                        xfer_done_d = 1'b1;
                        state_d     = WAIT_STOP;
                    end
                end
            end
            default: ;
        endcase

        if (start_det) begin
            state_d     = ADDR;
            bit_cnt_d   = 4'd0;
            drive_low_d = 1'b0;
        end else if (stop_det) begin
            state_d     = IDLE;
            drive_low_d = 1'b0;
        end
    end

endmodule

// File: doc/joypad_responder.md
JOYPAD_RESPONDER -- requirements
Module: joypad_responder

Interface
REQ-001 Parameter: DEV_ADDR, default 7'h52, the 7-bit target address this block answers to.
REQ-002 Port: clk  input  1  system clock; all logic is in this single clock domain.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: scl_in  input  1  serial clock from the initiator (asynchronous to clk).
REQ-005 Port: sda_in  input  1  serial data line as seen on the wire (asynchronous to clk).
REQ-006 Port: sda_out  output  1  open-drain drive: 0 pulls the line low, 1 releases it.
REQ-007 Port: buttons  input  32  live button and axis state; it is snapshotted per transfer.
REQ-008 Port: busy  output  1  high from a detected START until a detected STOP.
REQ-009 Port: xfer_done  output  1  one-cycle pulse when a read transfer ends with the initiator's NACK.

Function
REQ-010 scl_in and sda_in SHALL each pass through a 2-flop synchronizer; all protocol decisions SHALL use only the synchronized values and their registered previous values.
REQ-011 START SHALL be a synchronized sda falling edge while synchronized scl is high.
REQ-012 STOP SHALL be a synchronized sda rising edge while synchronized scl is high.
REQ-013 Data bits SHALL be sampled on the synchronized scl rising edge.
REQ-014 sda_out SHALL change only in the clk cycle after a synchronized scl falling edge, or on START, STOP or reset.
REQ-015 The state machine SHALL have the states IDLE, ADDR, ADDR_ACK, TX, RX_ACK and WAIT_STOP.
REQ-016 START SHALL enter ADDR from any state, including repeated START, and SHALL clear the bit counter.
REQ-017 STOP SHALL enter IDLE from any state and SHALL release sda_out.
REQ-018 ADDR SHALL shift in 8 bits MSB first: 7 address bits, then R/W.
REQ-019 If the address equals DEV_ADDR and R/W=1, the block SHALL:
  - drive sda_out=0 for the 9th scl period (ADDR_ACK);
  - latch buttons into a 32-bit snapshot on the scl falling edge that begins that ACK;
  - set the byte index to 0.
REQ-020 On an address mismatch or R/W=0, the block SHALL keep sda_out=1 (NACK) and go to WAIT_STOP; it SHALL ignore all traffic there except START and STOP.
REQ-021 TX SHALL present byte k = snapshot[8k+7:8k], MSB first:
  - the first bit is driven after the scl falling edge that ends the ACK;
  - each later bit is driven after each following falling edge.
REQ-022 After 8 data bits the block SHALL release sda_out and sample the initiator's bit on the 9th scl rising edge (RX_ACK).
REQ-023 In RX_ACK, a sampled 0 (ACK) SHALL increment the byte index modulo 4 (byte 3 wraps to byte 0 of the same snapshot) and return to TX.
REQ-024 In RX_ACK, a sampled 1 (NACK) SHALL pulse xfer_done for exactly one cycle and go to WAIT_STOP with sda_out=1.
REQ-025 The snapshot SHALL NOT change during a transfer; only a new matching address phase SHALL re-latch it.
REQ-026 If START or STOP occurs while the block is driving sda_out=0, it SHALL release sda_out in the same cycle the event is detected.
REQ-027 The block SHALL operate correctly when clk is at least 8x the scl frequency; from a scl_in edge to the resulting sda_out change SHALL be at most 4 clk cycles.

Reset
REQ-028 While rst_n=0, the block SHALL hold state=IDLE, sda_out=1, busy=0, xfer_done=0, snapshot=0, byte index=0, bit counter=0, and synchronizer flops=1.
REQ-029 Reset asserted mid-transfer SHALL release sda_out immediately (asynchronously).
REQ-030 After reset deasserts, the block SHALL ignore the bus until it detects a START.

Verification
REQ-031 Scenario: buttons=32'hA5C3_0F81, initiator sends START, 0xA5 (0x52 plus read), ACKs three bytes, NACKs the fourth, then sends STOP -> the block ACKs the address; bytes 0x81, 0x0F, 0xC3, 0xA5 appear on the line; xfer_done pulses once; busy falls after STOP.
REQ-032 Scenario: START, 0xA7 (address 0x53) -> the 9th bit reads 1 (NACK); sda_out stays 1 until STOP; xfer_done never pulses.
REQ-033 Scenario: START, 0xA4 (write to 0x52) -> NACK; block stays in WAIT_STOP; a following START and 0xA5 are ACKed normally.
REQ-034 Scenario: initiator ACKs 5 bytes with buttons=32'h0403_0201 -> reads 0x01, 0x02, 0x03, 0x04, 0x01 (wrap); changing buttons mid-read does not alter the bytes.
REQ-035 Scenario: repeated START in the middle of byte 1 while the block drives a 0 bit -> sda_out is 1 within 4 clk cycles; the new address is decoded and a fresh snapshot is taken.
REQ-036 Scenario: rst_n pulsed low during TX while sda_out=0 -> sda_out=1 asynchronously; the next transfer starting with START completes correctly.
